mult4u_share_ctrl: RTL and testbench

// Time-shares one combinational 4x4 unsigned multiplier (8-bit product) among NREQ requesters.
// - Round-robin arbitration; valid/ready handshake on request and response sides.
// - Operands are registered before driving the multiplier.
// - Sits between requesting datapath blocks and a single multiplier instance, which lives outside this block.

---
 rtl/mult4u_share_if.sv | 29 ++
 rtl/mult4u_share_ctrl.sv | 161 ++++++++++++++++
 tb/tb_mult4u_share_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mult4u_share_if.sv
// Handshake bundle between requesters, the sharing controller and the external 4x4 multiplier.
interface mult4u_share_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 3
);
  logic [NREQ-1:0]   req_valid;
  logic [4*NREQ-1:0] req_a;
  logic [4*NREQ-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic [3:0]        mul_a;
  logic [3:0]        mul_b;
  logic [7:0]        mul_p;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [7:0]        rsp_p;
  logic              rsp_err;
  logic              busy;

  modport slave (
    input  req_valid, req_a, req_b, mul_p, rsp_ready,
    output req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_p, rsp_err, busy
  );

  modport master (
    output req_valid, req_a, req_b, mul_p, rsp_ready,
    input  req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_p, rsp_err, busy
  );
endinterface

// File: rtl/mult4u_share_ctrl.sv
// Round-robin time-sharing of one external 4x4 unsigned multiplier among NREQ requesters.
// Optional MULT_RECHECK_EN adds a swapped-operand re-execution cycle that flags multiplier faults.
//
// state   | meaning
// S_IDLE  | waiting for a request; grants one requester combinationally
// S_ISSUE | latched operands drive the multiplier; product captured at the edge
// S_CHECK | operands swapped and product compared (MULT_RECHECK_EN only)
// S_RESP  | response held until rsp_ready
module mult4u_share_ctrl #(
  parameter int NREQ = 4,
  parameter int IDW  = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  mult4u_share_if.slave       bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_CHECK = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [IDW-1:0]  r_rr_ptr;
  logic [3:0]      r_op_a;
  logic [3:0]      r_op_b;
  logic [IDW-1:0]  r_id;
  logic [7:0]      r_res;

  logic            w_found_hi;
  logic            w_found_lo;
  logic [IDW-1:0]  w_gnt_hi;
  logic [IDW-1:0]  w_gnt_lo;
  logic            w_found;
  logic [IDW-1:0]  w_gnt;
  logic [3:0]      w_sel_a;
  logic [3:0]      w_sel_b;
  logic            w_accept;

`ifdef MULT_RECHECK_EN
  logic            r_err;
`endif

  // Round-robin: lowest requester above the last grant wins, otherwise wrap to the lowest overall.
  always_comb begin
    w_found_hi = 1'b0;
    w_found_lo = 1'b0;
    w_gnt_hi   = '0;
    w_gnt_lo   = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (bus.req_valid[j]) begin
        w_found_lo = 1'b1;
        w_gnt_lo   = IDW'(j);
        if (j > int'(r_rr_ptr)) begin
          w_found_hi = 1'b1;
          w_gnt_hi   = IDW'(j);
        end
      end
    end
    w_found = w_found_hi | w_found_lo;
    w_gnt   = w_found_hi ? w_gnt_hi : w_gnt_lo;
  end

  assign w_accept = (r_state == S_IDLE) && w_found;

  always_comb begin
    w_sel_a       = '0;
    w_sel_b       = '0;
    bus.req_ready = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (w_gnt == IDW'(j)) begin
        w_sel_a          = bus.req_a[4*j +: 4];
        w_sel_b          = bus.req_b[4*j +: 4];
        bus.req_ready[j] = w_accept;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    bus.mul_a = '0;
    bus.mul_b = '0;
    case (r_state)
      S_IDLE: begin
        if (w_found) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        bus.mul_a = r_op_a;
        bus.mul_b = r_op_b;
`ifdef MULT_RECHECK_EN
        w_next    = S_CHECK;
`else
        w_next    = S_RESP;
`endif
      end
      S_CHECK: begin
`ifdef MULT_RECHECK_EN
        // Commuted operands exercise different multiplier paths for the same product.
        bus.mul_a = r_op_b;
        bus.mul_b = r_op_a;
`endif
        w_next    = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= IDW'(NREQ - 1);
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_id     <= '0;
      r_res    <= '0;
    end else begin
      if (w_accept) begin
        r_op_a   <= w_sel_a;
        r_op_b   <= w_sel_b;
        r_id     <= w_gnt;
        r_rr_ptr <= w_gnt;
      end
      if (r_state == S_ISSUE) r_res <= bus.mul_p;
    end
  end

`ifdef MULT_RECHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= 1'b0;
    end else if (r_state == S_CHECK) begin
      r_err <= (bus.mul_p != r_res);
    end
  end

  assign bus.rsp_err = (r_state == S_RESP) ? r_err : 1'b0;
`else
  assign bus.rsp_err = 1'b0;
`endif

  assign bus.rsp_valid = (r_state == S_RESP);
  assign bus.rsp_p     = (r_state == S_RESP) ? r_res : 8'd0;
  assign bus.rsp_id    = (r_state == S_RESP) ? r_id : '0;
  assign bus.busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_mult4u_share_ctrl.sv
// Directed bench for mult4u_share_ctrl; models the external multiplier as a*b (plus optional stuck bit).
module tb_mult4u_share_ctrl;
  localparam int NREQ = 4;
  localparam int IDW  = 3;
`ifdef MULT_RECHECK_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic inj   = 1'b0;
  int   n_assert = 0;
  int   n_fail   = 0;

  mult4u_share_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  mult4u_share_ctrl #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  assign bus.mul_p = ({4'd0, bus.mul_a} * {4'd0, bus.mul_b}) | {7'd0, inj};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int idx, input logic [3:0] a, input logic [3:0] b);
    bus.req_a[4*idx +: 4] = a;
    bus.req_b[4*idx +: 4] = b;
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 12) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
  endtask

  task automatic expect_rsp(input string tag, input int id, input int p);
    wait_rsp(tag);
    chk({tag, "_id"}, 32'(bus.rsp_id), id);
    chk({tag, "_p"}, 32'(bus.rsp_p), p);
    chk({tag, "_err"}, 32'(bus.rsp_err), 32'd0);
    tick();
    chk({tag, "_drop"}, 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_mul", {24'd0, bus.mul_a, bus.mul_b}, 32'd0);
    chk("rst_rsp", {22'd0, bus.rsp_valid, bus.rsp_id, bus.rsp_p}, 32'd0);
    chk("rst_err_busy", {30'd0, bus.rsp_err, bus.busy}, 32'd0);
    rst_n = 1'b1;
    tick();

    // single request, 13*11
    set_req(0, 4'd13, 4'd11);
    bus.req_valid = 4'b0001;
    #1;
    chk("single_ready", 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = '0;
    chk("single_busy", 32'(bus.busy), 32'd1);
    chk("single_mul", {24'd0, bus.mul_a, bus.mul_b}, {24'd0, 4'd13, 4'd11});
    chk("single_noready", 32'(bus.req_ready), 32'd0);
    chk("single_early", 32'(bus.rsp_valid), 32'd0);
    repeat (LAT - 1) tick();
    chk("single_lat", 32'(bus.rsp_valid), 32'd1);
    chk("single_mul_idle", {24'd0, bus.mul_a, bus.mul_b}, 32'd0);
    expect_rsp("single", 0, 143);

    // fairness from a fresh reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 4'(i + 1), 4'd3);
    bus.req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("fair%0d_ready", k), 32'(bus.req_ready), 32'(1 << (k % 4)));
      tick();
      expect_rsp($sformatf("fair%0d", k), k % 4, ((k % 4) + 1) * 3);
    end
    bus.req_valid = '0;

    // backpressure with 15*15 from requester 2, requester 1 waiting
    set_req(2, 4'd15, 4'd15);
    set_req(1, 4'd1, 4'd1);
    bus.req_valid = 4'b0100;
    bus.rsp_ready = 1'b0;
    #1;
    chk("bp_ready", 32'(bus.req_ready), 32'b0100);
    tick();
    bus.req_valid = 4'b0010;
    wait_rsp("bp");
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_hold_p", 32'(bus.rsp_p), 32'd225);
      chk("bp_hold_id", 32'(bus.rsp_id), 32'd2);
      chk("bp_hold_busy", 32'(bus.busy), 32'd1);
      chk("bp_hold_ready", 32'(bus.req_ready), 32'd0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    chk("bp_drop", 32'(bus.rsp_valid), 32'd0);
    chk("bp_next_ready", 32'(bus.req_ready), 32'b0010);
    tick();
    bus.req_valid = '0;
    expect_rsp("one", 1, 1);

    // requester 3 withdraws before acceptance; requester 0 served with 0*15
    set_req(3, 4'd9, 4'd9);
    bus.req_valid = 4'b1000;
    #1;
    chk("skip_ready3", 32'(bus.req_ready), 32'b1000);
    set_req(0, 4'd0, 4'd15);
    bus.req_valid = 4'b0001;
    #1;
    chk("skip_ready0", 32'(bus.req_ready), 32'b0001);
    tick();
    bus.req_valid = '0;
    expect_rsp("zero", 0, 0);

    // full operand sweep through requester 1
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        set_req(1, 4'(a), 4'(b));
        bus.req_valid = 4'b0010;
        tick();
        bus.req_valid = '0;
        expect_rsp($sformatf("sweep_%0dx%0d", a, b), 1, a * b);
      end
    end

    // reset during ISSUE discards the transaction
    set_req(2, 4'd5, 4'd5);
    bus.req_valid = 4'b0100;
    tick();
    bus.req_valid = '0;
    chk("rmid_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rmid_busy_clr", 32'(bus.busy), 32'd0);
    chk("rmid_mul_clr", {24'd0, bus.mul_a, bus.mul_b}, 32'd0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("rmid_norsp", 32'(bus.rsp_valid), 32'd0);
      tick();
    end
    set_req(0, 4'd7, 4'd9);
    bus.req_valid = 4'b1111;
    #1;
    chk("rmid_prio", 32'(bus.req_ready), 32'b0001);
    tick();
    bus.req_valid = '0;
    expect_rsp("rmid", 0, 63);

`ifdef MULT_RECHECK_EN
    // stuck-at-1 on product bit 0 during the CHECK cycle only
    set_req(0, 4'd2, 4'd3);
    bus.req_valid = 4'b0001;
    tick();
    bus.req_valid = '0;
    tick();
    inj = 1'b1;
    #1;
    chk("chk_swap", {24'd0, bus.mul_a, bus.mul_b}, {24'd0, 4'd3, 4'd2});
    tick();
    inj = 1'b0;
    chk("chk_fault_valid", 32'(bus.rsp_valid), 32'd1);
    chk("chk_fault_err", 32'(bus.rsp_err), 32'd1);
    chk("chk_fault_p", 32'(bus.rsp_p), 32'd6);
    tick();
    bus.req_valid = 4'b0001;
    tick();
    bus.req_valid = '0;
    expect_rsp("chk_ok", 0, 6);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
